// File: rtl/bus_arbiter.sv
// bus_arbiter: 4-requester round-robin bus arbiter with registered one-hot
// grant, combinational data mux and back-pressure-safe hold counter.
// Optional feature: define ARB_HOLD_LIMIT_EN to force release after HOLD_MAX
// transfers in a single grant (HOLD_MAX legal range 1..15).
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  input  logic       bus_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid,
  output logic [7:0] bus_data
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Elaboration-time guard on the hold limit range
  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_max_check
    $error("bus_arbiter: HOLD_MAX must be in 1..15");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_valid_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [IDX_W-1:0]   scan_idx_c;
  logic               xfer_c;
  logic               hold_done_c;
  logic               release_c;
  logic               grant_new_c;

  // Round-robin search starting at ptr; the previous owner is examined last
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = ptr_q;
    scan_idx_c  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx_c = IDX_W'(ptr_q + IDX_W'(i));
      if (!win_valid_c && req[scan_idx_c]) begin
        win_valid_c = 1'b1;
        win_idx_c   = scan_idx_c;
      end
    end
  end

  assign bus_valid = (state_q == ST_GRANT) && req[sel_q];
  assign xfer_c    = bus_valid && bus_ready;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  assign hold_done_c = xfer_c && (cnt_q == HOLD_LAST);
`else
  assign hold_done_c = 1'b0;
`endif

  // Owner drop or hold-limit expiry ends the current grant; a stalled
  // transfer keeps req[sel] high and never reaches the limit, so it holds.
  assign release_c   = (state_q == ST_GRANT) && (!req[sel_q] || hold_done_c);
  assign grant_new_c = win_valid_c && ((state_q == ST_IDLE) || release_c);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req != '0) state_d = ST_GRANT;
      ST_GRANT: if (release_c && !win_valid_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant, owner index, search pointer and hold counter updates
  always_comb begin
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (grant_new_c) begin
      gnt_d = N_REQ'(4'b0001 << win_idx_c);
      sel_d = win_idx_c;
      ptr_d = IDX_W'(win_idx_c + IDX_W'(1));
      cnt_d = '0;
    end else if (release_c) begin
      gnt_d = '0;
      cnt_d = '0;
    end else if (xfer_c) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Data mux follows sel in every state, including IDLE
  always_comb begin
    case (sel_q)
      2'd0:    bus_data = din0;
      2'd1:    bus_data = din1;
      2'd2:    bus_data = din2;
      default: bus_data = din3;
    endcase
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expectations are queued when each step is
// driven and popped for comparison once the DUT has responded.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;
  logic       bus_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic [7:0] bus_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] data;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  bus_arbiter #(.HOLD_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .din2     (din2),
    .din3     (din3),
    .bus_ready(bus_ready),
    .gnt      (gnt),
    .sel      (sel),
    .bus_valid(bus_valid),
    .bus_data (bus_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] din_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h10;
      2'd1:    return 8'h21;
      2'd2:    return 8'hA5;
      default: return 8'h3C;
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] g, input logic [1:0] s,
                          input logic v, input logic [7:0] d, input string tag);
    exp_t e;
    e.gnt = g; e.sel = s; e.valid = v; e.data = d; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
    end
    checks++;
    assert (sel === e.sel) else begin
      errors++;
      $error("FAIL %s sel observed=%0d expected=%0d", e.tag, sel, e.sel);
    end
    checks++;
    assert (bus_valid === e.valid) else begin
      errors++;
      $error("FAIL %s bus_valid observed=%b expected=%b", e.tag, bus_valid, e.valid);
    end
    checks++;
    assert (bus_data === e.data) else begin
      errors++;
      $error("FAIL %s bus_data observed=%h expected=%h", e.tag, bus_data, e.data);
    end
  endtask

  task automatic check_cnt(input logic [3:0] exp_cnt, input string tag);
    checks++;
    assert (dut.cnt_q === exp_cnt) else begin
      errors++;
      $error("FAIL %s counter observed=%0d expected=%0d", tag, dut.cnt_q, exp_cnt);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then check outputs
  task automatic step(input logic [3:0] r, input logic rd,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic ev, input logic [7:0] ed, input string tag);
    @(negedge clk);
    req       = r;
    bus_ready = rd;
    push_exp(eg, es, ev, ed, tag);
    #1;
    pop_check();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    req       = 4'b0000;
    bus_ready = 1'b1;
    push_exp(4'b0000, 2'd0, 1'b0, 8'h10, tag);
    #1;
    pop_check();
    check_cnt(4'd0, {tag, "_cnt"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] own;
    rst       = 1'b1;
    req       = 4'b0000;
    bus_ready = 1'b1;
    din0 = 8'h10; din1 = 8'h21; din2 = 8'hA5; din3 = 8'h3C;

    // Single requester
    do_reset("reset0");
    step(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h10, "single_idle");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, "single_gnt1");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, "single_gnt2");
    step(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 8'hA5, "single_drop");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 8'hA5, "single_idle2");

    // Round robin with all requesters, each owner dropping after one transfer
    do_reset("reset_rr");
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h10, "rr_idle");
    step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10, "rr_own0");
    step(4'b1110, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h10, "rr_drop0");
    step(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21, "rr_own1");
    step(4'b1101, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h21, "rr_drop1");
    step(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, "rr_own2");
    step(4'b1011, 1'b1, 4'b0100, 2'd2, 1'b0, 8'hA5, "rr_drop2");
    step(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C, "rr_own3");
    step(4'b0111, 1'b1, 4'b1000, 2'd3, 1'b0, 8'h3C, "rr_drop3");
    step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10, "rr_own0_again");

    // Back-pressure on owner 1
    step(4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h10, "bp_release");
    step(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h10, "bp_idle");
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h21, "bp_stall");
      check_cnt(4'd0, "bp_stall_cnt");
    end
    step(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21, "bp_resume");
    check_cnt(4'd0, "bp_resume_cnt");
    step(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h21, "bp_after");
    check_cnt(4'd1, "bp_after_cnt");

    // Owner 2 drops with requester 0 pending
    step(4'b0100, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h21, "drop_handoff");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, "drop_own2");
    step(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, "drop_pending");
    step(4'b0001, 1'b1, 4'b0100, 2'd2, 1'b0, 8'hA5, "drop_same_cycle");
    step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10, "drop_next_gnt");

    // Hold limit: HOLD_MAX=3 when compiled in, otherwise owner 0 keeps it
    do_reset("reset_hold");
    step(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h10, "hold_idle");
    for (int i = 0; i < 9; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
      own = 2'((i / 3) % 2);
`else
      own = 2'd0;
`endif
      step(4'b0011, 1'b1, 4'(4'b0001 << own), own, 1'b1, din_of(own), "hold_owner");
    end

    // Asynchronous reset in the middle of a grant to owner 3
    do_reset("reset_mid");
    step(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h10, "mid_idle");
    step(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C, "mid_own3");
    #2;
    rst = 1'b1;
    push_exp(4'b0000, 2'd0, 1'b0, 8'h10, "mid_async_rst");
    #1;
    pop_check();
    check_cnt(4'd0, "mid_async_cnt");
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    step(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10, "mid_first_gnt0");
    step(4'b1000, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h10, "mid_drop0");
    step(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h3C, "mid_then3");

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning the maximum number of transfers per grant when the limit is compiled in; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester bus request; bit i is requester i.
REQ-005 SHALL have ports din0..din3  input  8 each  per-requester data.
REQ-006 SHALL have port bus_ready  input  1  downstream accepts bus_data this cycle.
REQ-007 SHALL have port gnt  output  4  one-hot registered grant, or all-zero.
REQ-008 SHALL have port sel  output  2  registered index of the current owner; drives the 4:1 data mux.
REQ-009 SHALL have port bus_valid  output  1  bus_data is valid this cycle.
REQ-010 SHALL have port bus_data  output  8  data of the selected requester.

Function
REQ-011 SHALL implement two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-012 SHALL, in IDLE with req!=0 at a clock edge, enter GRANT on that edge with 1-cycle latency from req to gnt.
REQ-013 SHALL pick the winner round-robin: search from ptr upward modulo 4; the first set req bit wins.
REQ-014 SHALL, on every grant, load sel with the winner index and set ptr to winner+1 mod 4, so the last owner is searched last.
REQ-015 SHALL drive bus_data = din[sel] combinationally in every state, and 0x00 is not forced in IDLE.
REQ-016 SHALL drive bus_valid = (state==GRANT) & req[sel], combinationally.
REQ-017 SHALL count a transfer in any cycle where bus_valid & bus_ready.
REQ-018 SHALL release the grant at the edge where req[sel] is sampled low.
REQ-019 SHALL, on release with other req bits set, grant the next winner on the same edge with no IDLE bubble.
REQ-020 SHALL, on release with no req bits set, go to IDLE.
REQ-021 SHALL, when the owner drops req, deassert bus_valid in the same cycle and clear gnt at the next edge.
REQ-022 SHALL re-grant the released owner immediately if it is the only requester.
REQ-023 SHALL leave req changes of non-owners without effect on the current grant.
REQ-024 SHALL hold the 4-bit hold counter at 0 in IDLE, clear it on every new grant, and increment it on each transfer.
REQ-025 SHALL hold gnt, sel and the counter unchanged while bus_valid & !bus_ready, so no data is lost under back-pressure.

Reset
REQ-026 SHALL, on rst asserted (asynchronous), immediately set state=IDLE, gnt=4'b0000, sel=2'b00, ptr=0 and counter=0.
REQ-027 SHALL hold bus_valid at 0 while in reset.
REQ-028 SHALL abandon any in-flight grant when reset is asserted mid-operation.
REQ-029 SHALL, after rst deasserts, start arbitration at the first rising edge with requester 0 highest priority.

Configuration
REQ-030 SHALL, with ARB_HOLD_LIMIT_EN defined, force release at the edge of the HOLD_MAX-th transfer of a grant, even if req[sel] stays high.
REQ-031 SHALL, on a forced release, select the next owner per REQ-013 and REQ-019, and re-grant the same owner if it is the only requester.
REQ-032 SHALL, with ARB_HOLD_LIMIT_EN undefined, keep the grant until req[sel] drops, leave HOLD_MAX unused, and keep the counter behaviour observable only internally.

Verification
REQ-033 SHALL cover single requester: reset, req=4'b0100, bus_ready=1, din2=0xA5 -> gnt=4'b0100 and sel=2 one cycle later; bus_valid=1 and bus_data=0xA5 every cycle until req drops.
REQ-034 SHALL cover round-robin: req=4'b1111 held, each owner dropping req after 1 transfer -> grant order 0,1,2,3,0 with no IDLE cycle between grants.
REQ-035 SHALL cover back-pressure: owner 1 granted, bus_ready=0 for 5 cycles -> bus_valid=1 throughout; gnt, sel and counter unchanged; counter increments only when bus_ready returns to 1.
REQ-036 SHALL cover the hold limit with ARB_HOLD_LIMIT_EN, HOLD_MAX=3, req=4'b0011 held, bus_ready=1 -> owner 0 for 3 transfers, then owner 1 for 3, then owner 0; without the macro, owner 0 keeps the grant indefinitely.
REQ-037 SHALL cover reset mid-grant: owner 3 granted, rst pulsed between clock edges -> gnt=0, sel=0 and bus_valid=0 asynchronously; with req=4'b1001 after release, owner 0 is granted first.
REQ-038 SHALL cover owner drop: owner 2 drops req while req0 is pending -> bus_valid falls the same cycle; gnt=4'b0001 at the next edge.
